// File: rtl/flash_cmd_pkg.sv
// ============================================================================
// Module   : flash_cmd_pkg
// Purpose  : Opcodes and sequencer state encoding shared by the flash writer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package flash_cmd_pkg;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_SE   = 8'h20;
  localparam logic [7:0] OP_RDSR = 8'h05;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WREN      = 4'd1,
    ST_GAP       = 4'd2,
    ST_CMD       = 4'd3,
    ST_ADDR      = 4'd4,
    ST_DATA      = 4'd5,
    ST_POLL_CMD  = 4'd6,
    ST_POLL_READ = 4'd7,
    ST_DONE      = 4'd8
  } state_t;

  // Main command opcode for the selected operation
  function automatic logic [7:0] cmd_opcode(input logic is_erase);
    return is_erase ? OP_SE : OP_PP;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_byte_shift.sv
// ============================================================================
// Module   : spi_byte_shift
// Purpose  : SPI mode-0 byte shifter, MSB first, CLK_DIV clk cycles per
//            half-period of sclk; start/done handshake, sclk idles low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_byte_shift #(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       done,
  output logic [7:0] rx_byte
);

  logic        active;
  logic        phase_high;
  logic [15:0] div_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;

  // Half-period timer drives sclk; mosi changes only on the falling edge
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      active     <= 1'b0;
      phase_high <= 1'b0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      done       <= 1'b0;
      rx_byte    <= '0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (start) begin
          active     <= 1'b1;
          phase_high <= 1'b0;
          div_cnt    <= '0;
          bit_cnt    <= '0;
          shreg      <= tx_byte;
          mosi       <= tx_byte[7];
        end
      end else if (div_cnt != 16'(CLK_DIV - 1)) begin
        div_cnt <= div_cnt + 16'd1;
      end else begin
        div_cnt <= '0;
        if (!phase_high) begin
          sclk       <= 1'b1;
          phase_high <= 1'b1;
          rx_byte    <= {rx_byte[6:0], miso};
        end else begin
          sclk       <= 1'b0;
          phase_high <= 1'b0;
          if (bit_cnt == 3'd7) begin
            active <= 1'b0;
            done   <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            shreg   <= {shreg[6:0], 1'b0};
            mosi    <= shreg[6];
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/flash_writer.sv
// ============================================================================
// Module   : flash_writer
// Purpose  : SPI NOR page-program / sector-erase sequencer with WIP polling.
//            Define FLASH_WRITER_ERASE_EN to enable the 4 KB sector erase
//            path; otherwise the erase input is ignored.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_writer
  import flash_cmd_pkg::*;
#(
  parameter int          CLK_DIV    = 1,
  parameter int          CS_GAP     = 8,
  parameter logic [23:0] POLL_LIMIT = 24'd2000000
) (
  input  logic        clk,
  input  logic        resetN,
  output logic        flashClk,
  output logic        flashMosi,
  output logic        flashCs,
  input  logic        flashMiso,
  input  logic        start,
  input  logic [23:0] address,
  input  logic [8:0]  byteCount,
  input  logic        erase,
  input  logic [7:0]  dataIn,
  input  logic        dataValid,
  output logic        dataReady,
  output logic        busy,
  output logic        done,
  output logic        error
);

  state_t      state;
  state_t      ret_state;
  logic        sh_start;
  logic [7:0]  sh_tx;
  logic        sh_done;
  logic [7:0]  sh_rx;
  logic        launched;
  logic [23:0] addr_r;
  logic [8:0]  bytes_left;
  logic [1:0]  addr_idx;
  logic [15:0] gap_cnt;
  logic [23:0] poll_cnt;
  logic [7:0]  addr_byte;
  logic        erase_req;
  logic        is_erase;
  logic        unused_rx;

`ifdef FLASH_WRITER_ERASE_EN
  logic erase_r;
  assign erase_req = erase;
  assign is_erase  = erase_r;
`else
  logic unused_erase;
  assign unused_erase = erase;
  assign erase_req    = 1'b0;
  assign is_erase     = 1'b0;
`endif

  assign unused_rx = ^sh_rx[7:1];

  spi_byte_shift #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk     (clk),
    .resetN  (resetN),
    .start   (sh_start),
    .tx_byte (sh_tx),
    .miso    (flashMiso),
    .sclk    (flashClk),
    .mosi    (flashMosi),
    .done    (sh_done),
    .rx_byte (sh_rx)
  );

  // Address is sent high byte first
  always_comb begin
    addr_byte = addr_r[7:0];
    case (addr_idx)
      2'd0:    addr_byte = addr_r[23:16];
      2'd1:    addr_byte = addr_r[15:8];
      default: addr_byte = addr_r[7:0];
    endcase
  end

  // Transaction sequencer; every byte is launched once and advances on sh_done
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= ST_IDLE;
      ret_state  <= ST_IDLE;
      flashCs    <= 1'b1;
      dataReady  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      sh_start   <= 1'b0;
      sh_tx      <= '0;
      launched   <= 1'b0;
      addr_r     <= '0;
      bytes_left <= '0;
      addr_idx   <= '0;
      gap_cnt    <= '0;
      poll_cnt   <= '0;
`ifdef FLASH_WRITER_ERASE_EN
      erase_r    <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      sh_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_r     <= address;
            bytes_left <= byteCount;
`ifdef FLASH_WRITER_ERASE_EN
            erase_r    <= erase;
`endif
            if (!erase_req && (byteCount == 9'd0 || byteCount > 9'd256)) begin
              done  <= 1'b1;
              error <= 1'b1;
            end else begin
              error    <= 1'b0;
              busy     <= 1'b1;
              flashCs  <= 1'b0;
              launched <= 1'b0;
              state    <= ST_WREN;
            end
          end
        end
        ST_WREN: begin
          if (!launched) begin
            sh_start <= 1'b1;
            sh_tx    <= OP_WREN;
            launched <= 1'b1;
          end else if (sh_done) begin
            launched  <= 1'b0;
            flashCs   <= 1'b1;
            gap_cnt   <= '0;
            ret_state <= ST_CMD;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 16'(CS_GAP - 1)) begin
            flashCs <= 1'b0;
            state   <= ret_state;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        ST_CMD: begin
          if (!launched) begin
            sh_start <= 1'b1;
            sh_tx    <= cmd_opcode(is_erase);
            launched <= 1'b1;
          end else if (sh_done) begin
            launched <= 1'b0;
            addr_idx <= '0;
            state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (!launched) begin
            sh_start <= 1'b1;
            sh_tx    <= addr_byte;
            launched <= 1'b1;
          end else if (sh_done) begin
            launched <= 1'b0;
            if (addr_idx == 2'd2) begin
              if (is_erase) begin
                flashCs   <= 1'b1;
                gap_cnt   <= '0;
                ret_state <= ST_POLL_CMD;
                state     <= ST_GAP;
              end else begin
                dataReady <= 1'b1;
                state     <= ST_DATA;
              end
            end else begin
              addr_idx <= addr_idx + 2'd1;
            end
          end
        end
        ST_DATA: begin
          // While waiting for dataValid the shifter is idle, so sclk stays low
          if (!launched) begin
            if (dataValid && dataReady) begin
              dataReady <= 1'b0;
              sh_start  <= 1'b1;
              sh_tx     <= dataIn;
              launched  <= 1'b1;
            end
          end else if (sh_done) begin
            launched <= 1'b0;
            if (bytes_left == 9'd1) begin
              flashCs   <= 1'b1;
              gap_cnt   <= '0;
              ret_state <= ST_POLL_CMD;
              state     <= ST_GAP;
            end else begin
              bytes_left <= bytes_left - 9'd1;
              dataReady  <= 1'b1;
            end
          end
        end
        ST_POLL_CMD: begin
          if (!launched) begin
            sh_start <= 1'b1;
            sh_tx    <= OP_RDSR;
            launched <= 1'b1;
          end else if (sh_done) begin
            launched <= 1'b0;
            poll_cnt <= '0;
            state    <= ST_POLL_READ;
          end
        end
        ST_POLL_READ: begin
          if (!launched) begin
            sh_start <= 1'b1;
            sh_tx    <= 8'h00;
            launched <= 1'b1;
          end else if (sh_done) begin
            launched <= 1'b0;
            if (!sh_rx[0]) begin
              flashCs <= 1'b1;
              state   <= ST_DONE;
            end else if (poll_cnt == POLL_LIMIT - 24'd1) begin
              error   <= 1'b1;
              flashCs <= 1'b1;
              state   <= ST_DONE;
            end else begin
              poll_cnt <= poll_cnt + 24'd1;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          flashCs <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_flash_writer.sv
// ============================================================================
// Module   : tb_flash_writer
// Purpose  : Scoreboard bench for flash_writer with a behavioural SPI flash
//            model. Erase test is built when FLASH_WRITER_ERASE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_flash_writer;

  localparam int          CLK_DIV    = 2;
  localparam int          CS_GAP     = 8;
  localparam logic [23:0] POLL_LIMIT = 24'd5;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        flashClk, flashMosi, flashCs;
  logic        flashMiso = 1'b0;
  logic        start = 1'b0;
  logic [23:0] address = '0;
  logic [8:0]  byteCount = '0;
  logic        erase = 1'b0;
  logic [7:0]  dataIn = '0;
  logic        dataValid = 1'b0;
  logic        dataReady, busy, done, error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flash_writer #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .POLL_LIMIT(POLL_LIMIT)) dut (
    .clk(clk), .resetN(resetN), .flashClk(flashClk), .flashMosi(flashMosi),
    .flashCs(flashCs), .flashMiso(flashMiso), .start(start), .address(address),
    .byteCount(byteCount), .erase(erase), .dataIn(dataIn), .dataValid(dataValid),
    .dataReady(dataReady), .busy(busy), .done(done), .error(error)
  );

  // Scoreboard queues and flash-model state
  logic [7:0] exp_bytes[$];
  int         exp_lens[$];
  logic       exp_errs[$];
  logic [7:0] data_q[$];
  int         wip_count = 0;
  logic       wip_stuck = 1'b0;
  logic       aborting = 1'b0;
  int         cs_falls = 0;
  int         trans_bytes = 0;
  int         bit_n = 0;
  int         gap = 0;
  logic       in_op = 1'b0;
  logic [7:0] sh_in = '0;
  logic [7:0] first_byte = '0;
  logic [7:0] stat_sh = '0;
  logic       prev_sclk = 1'b0;
  logic       prev_cs = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Flash model and monitor: decode SPI bytes, answer RDSR, check against queues
  always @(negedge clk) begin
    if (aborting) begin
      bit_n       = 0;
      trans_bytes = 0;
      in_op       = 1'b0;
      flashMiso   = 1'b0;
    end else begin
      if (prev_cs && !flashCs) begin
        cs_falls++;
        if (in_op) check("cs_gap", 32'(gap >= CS_GAP), 32'd1);
        trans_bytes = 0;
        bit_n       = 0;
      end
      if (!prev_cs && flashCs) begin
        check("partial_bits", bit_n, 0);
        check("trans_len", trans_bytes, exp_lens.size() != 0 ? exp_lens.pop_front() : -1);
        in_op = 1'b1;
        gap   = 0;
      end
      if (flashCs) gap++;
      if (!flashCs && !prev_sclk && flashClk) begin
        sh_in = {sh_in[6:0], flashMosi};
        bit_n++;
        if (bit_n == 8) begin
          bit_n = 0;
          check("mosi_byte", {24'h0, sh_in},
                exp_bytes.size() != 0 ? {24'h0, exp_bytes.pop_front()} : 32'hDEAD);
          if (trans_bytes == 0) first_byte = sh_in;
          trans_bytes++;
          if (first_byte == 8'h05) begin
            stat_sh = (wip_stuck || wip_count > 0) ? 8'h03 : 8'h02;
            if (!wip_stuck && wip_count > 0) wip_count--;
            flashMiso = stat_sh[7];
          end
        end
      end
      if (!flashCs && prev_sclk && !flashClk && bit_n != 0) flashMiso = stat_sh[7 - bit_n];
      if (done) begin
        check("done_error", {31'h0, error},
              exp_errs.size() != 0 ? {31'h0, exp_errs.pop_front()} : 32'd2);
        in_op = 1'b0;
      end
    end
    prev_cs   = flashCs;
    prev_sclk = flashClk;
  end

  task automatic push_program(input logic [23:0] a, input int status_reads, input logic err);
    exp_bytes.push_back(8'h06);
    exp_lens.push_back(1);
    exp_bytes.push_back(8'h02);
    exp_bytes.push_back(a[23:16]);
    exp_bytes.push_back(a[15:8]);
    exp_bytes.push_back(a[7:0]);
    foreach (data_q[i]) exp_bytes.push_back(data_q[i]);
    exp_lens.push_back(4 + data_q.size());
    exp_bytes.push_back(8'h05);
    for (int i = 0; i < status_reads; i++) exp_bytes.push_back(8'h00);
    exp_lens.push_back(1 + status_reads);
    exp_errs.push_back(err);
  endtask

  task automatic issue_start(input logic [23:0] a, input logic [8:0] n, input logic er);
    @(negedge clk);
    address   = a;
    byteCount = n;
    erase     = er;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic feed_data(input int stall_idx, input int stall_cycles);
    for (int i = 0; i < data_q.size(); i++) begin
      int t = 0;
      while (!dataReady && t < 2000) begin
        @(negedge clk);
        t++;
      end
      check("ready_wait", {31'h0, dataReady}, 32'd1);
      if (i == stall_idx) begin
        for (int s = 0; s < stall_cycles; s++) begin
          check("stall_sclk", {31'h0, flashClk}, 32'd0);
          check("stall_cs", {31'h0, flashCs}, 32'd0);
          check("stall_ready", {31'h0, dataReady}, 32'd1);
          @(negedge clk);
        end
      end
      dataIn    = data_q[i];
      dataValid = 1'b1;
      @(negedge clk);
      dataValid = 1'b0;
      check("ready_drop", {31'h0, dataReady}, 32'd0);
    end
  endtask

  task automatic wait_done(output int ready_hits);
    int t = 0;
    ready_hits = 0;
    while (!done && t < 5000) begin
      if (dataReady) ready_hits++;
      @(negedge clk);
      t++;
    end
    check("done_seen", {31'h0, done}, 32'd1);
    check("busy_clear", {31'h0, busy}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int hits;
    int base;
    int t;

    repeat (3) @(negedge clk);
    check("rst_cs", {31'h0, flashCs}, 32'd1);
    check("rst_sclk", {31'h0, flashClk}, 32'd0);
    check("rst_mosi", {31'h0, flashMosi}, 32'd0);
    check("rst_ready", {31'h0, dataReady}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_error", {31'h0, error}, 32'd0);
    resetN = 1'b1;
    @(negedge clk);

    // Program, three WIP status bytes then ready
    data_q = '{8'hA5, 8'h5A, 8'h00, 8'hFF};
    wip_count = 3;
    push_program(24'h012340, 4, 1'b0);
    issue_start(24'h012340, 9'd4, 1'b0);
    check("busy_set", {31'h0, busy}, 32'd1);
    feed_data(-1, 0);
    wait_done(hits);

    // Stall before second data byte; page-crossing address passed through
    data_q = '{8'h11, 8'h22, 8'h33};
    wip_count = 0;
    push_program(24'h0000FE, 1, 1'b0);
    issue_start(24'h0000FE, 9'd3, 1'b0);
    feed_data(1, 20);
    wait_done(hits);

    // Illegal byte counts: no transaction, done next cycle with error
    base = cs_falls;
    exp_errs.push_back(1'b1);
    issue_start(24'h000100, 9'd0, 1'b0);
    check("cnt0_done", {31'h0, done}, 32'd1);
    check("cnt0_error", {31'h0, error}, 32'd1);
    @(negedge clk);
    check("cnt0_hold", {31'h0, error}, 32'd1);
    check("cnt0_pulse", {31'h0, done}, 32'd0);
    exp_errs.push_back(1'b1);
    issue_start(24'h000100, 9'd257, 1'b0);
    check("cnt257_done", {31'h0, done}, 32'd1);
    check("cnt257_error", {31'h0, error}, 32'd1);
    check("cnt257_busy", {31'h0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    check("no_cs_activity", cs_falls, base);

    // Poll timeout with WIP stuck
    data_q = '{8'hC3};
    wip_stuck = 1'b1;
    push_program(24'h1000FE, 5, 1'b1);
    issue_start(24'h1000FE, 9'd1, 1'b0);
    feed_data(-1, 0);
    wait_done(hits);
    wip_stuck = 1'b0;
    check("timeout_hold", {31'h0, error}, 32'd1);

    // Reset in the middle of the address phase
    data_q = '{8'h77};
    wip_count = 0;
    push_program(24'hABCDEF, 1, 1'b0);
    base = cs_falls;
    issue_start(24'hABCDEF, 9'd1, 1'b0);
    t = 0;
    while (!(cs_falls >= base + 2 && trans_bytes >= 2) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("reach_addr", 32'(cs_falls >= base + 2 && trans_bytes >= 2), 32'd1);
    repeat (4) @(negedge clk);
    #2;
    aborting = 1'b1;
    resetN   = 1'b0;
    #1;
    check("abort_cs", {31'h0, flashCs}, 32'd1);
    check("abort_sclk", {31'h0, flashClk}, 32'd0);
    check("abort_busy", {31'h0, busy}, 32'd0);
    check("abort_error", {31'h0, error}, 32'd0);
    exp_bytes.delete();
    exp_lens.delete();
    exp_errs.delete();
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    aborting = 1'b0;
    @(negedge clk);
    data_q = '{8'h9C, 8'h3E};
    push_program(24'hABCDEF, 1, 1'b0);
    issue_start(24'hABCDEF, 9'd2, 1'b0);
    feed_data(-1, 0);
    wait_done(hits);

`ifdef FLASH_WRITER_ERASE_EN
    // Sector erase: no data phase, one WIP byte
    wip_count = 1;
    exp_bytes.push_back(8'h06);
    exp_lens.push_back(1);
    exp_bytes.push_back(8'h20);
    exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'h30);
    exp_bytes.push_back(8'h00);
    exp_lens.push_back(4);
    exp_bytes.push_back(8'h05);
    exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'h00);
    exp_lens.push_back(3);
    exp_errs.push_back(1'b0);
    issue_start(24'h003000, 9'd0, 1'b1);
    wait_done(hits);
    check("erase_no_ready", hits, 0);
`endif

    check("left_bytes", exp_bytes.size(), 0);
    check("left_lens", exp_lens.size(), 0);
    check("left_errs", exp_errs.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
